// File: rtl/fpu_ss_predecoder_pipe.sv
// fpu_ss_predecoder_pipe: per-port registered offload predecoder (mask/data table lookup, 1-entry output stage).
// Table entry = {instr_mask[31:0], instr_data[31:0], prd_rsp[6:0]}; prd_rsp = {p_accept, p_writeback[1:0], p_is_mem_op, p_use_rs[2:0]}.
module fpu_ss_predecoder_pipe #(
   parameter int unsigned                NumPorts     = 2,
   parameter int unsigned                NumInstr     = 1,
   parameter logic [NumInstr-1:0][70:0]  OffloadInstr = '0
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          flush_i,
   input  logic [NumPorts-1:0]           req_valid_i,
   output logic [NumPorts-1:0]           req_ready_o,
   input  logic [NumPorts-1:0][31:0]     prd_req_i,
   output logic [NumPorts-1:0]           rsp_valid_o,
   input  logic [NumPorts-1:0]           rsp_ready_i,
   output logic [NumPorts-1:0][6:0]      prd_rsp_o,
   output logic [NumPorts-1:0]           hit_o,
   output logic [NumPorts-1:0]           multi_hit_o
);
   typedef struct packed {
      logic       p_accept;
      logic [1:0] p_writeback;
      logic       p_is_mem_op;
      logic [2:0] p_use_rs;
   } acc_prd_rsp_t;
   typedef struct packed {
      logic [31:0]  instr_mask;
      logic [31:0]  instr_data;
      acc_prd_rsp_t prd_rsp;
   } offload_instr_t;
   typedef enum logic {S_EMPTY, S_FULL} state_e;
   localparam offload_instr_t [NumInstr-1:0] Tbl = OffloadInstr;
   for (genvar p = 0; p < NumPorts; p++) begin : g_port
      state_e       r_state, w_state_nxt;
      acc_prd_rsp_t r_rsp, w_rsp;
      logic         r_hit, r_multi, w_hit, w_multi, w_req_fire, w_rsp_fire;
      // Scan from the top so the lowest-index hit overwrites last and wins.
      always_comb begin
         w_hit   = 1'b0;
         w_multi = 1'b0;
         w_rsp   = '0;
         for (int i = NumInstr - 1; i >= 0; i--) begin
            if ((Tbl[i].instr_mask & prd_req_i[p]) == Tbl[i].instr_data) begin
               w_multi = w_multi | w_hit;
               w_hit   = 1'b1;
               w_rsp   = Tbl[i].prd_rsp;
            end
         end
      end
      assign req_ready_o[p] = !flush_i && (r_state == S_EMPTY || rsp_ready_i[p]);
      assign w_req_fire     = req_valid_i[p] && req_ready_o[p];
      assign w_rsp_fire     = (r_state == S_FULL) && rsp_ready_i[p];
      always_comb begin
         w_state_nxt = flush_i ? S_EMPTY : w_req_fire ? S_FULL : w_rsp_fire ? S_EMPTY : r_state;
      end
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) r_state <= S_EMPTY;
         else       r_state <= w_state_nxt;
      end
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_rsp   <= '0;
            r_hit   <= 1'b0;
            r_multi <= 1'b0;
         end else if (w_req_fire) begin
            r_rsp   <= w_rsp;
            r_hit   <= w_hit;
            r_multi <= w_multi;
         end
      end
      assign rsp_valid_o[p] = (r_state == S_FULL);
      assign prd_rsp_o[p]   = r_rsp;
      assign hit_o[p]       = r_hit;
      assign multi_hit_o[p] = r_multi;
   end
endmodule

// File: tb/tb_fpu_ss_predecoder_pipe.sv
// tb_fpu_ss_predecoder_pipe: scoreboard bench for the two-port predecoder with a table-lookup reference model.
module tb_fpu_ss_predecoder_pipe;
   typedef struct packed {
      logic       p_accept;
      logic [1:0] p_writeback;
      logic       p_is_mem_op;
      logic [2:0] p_use_rs;
   } acc_prd_rsp_t;
   typedef struct packed {
      logic [31:0]  instr_mask;
      logic [31:0]  instr_data;
      acc_prd_rsp_t prd_rsp;
   } offload_instr_t;
   typedef struct {
      logic [6:0] rsp;
      logic       hit;
      logic       multi;
   } exp_t;

   localparam offload_instr_t E0 = '{instr_mask: 32'h7F, instr_data: 32'h53,
      prd_rsp: '{p_accept: 1'b1, p_writeback: 2'b01, p_is_mem_op: 1'b0, p_use_rs: 3'b011}};
   localparam offload_instr_t E1 = '{instr_mask: 32'h707F, instr_data: 32'h1053,
      prd_rsp: '{p_accept: 1'b1, p_writeback: 2'b00, p_is_mem_op: 1'b0, p_use_rs: 3'b001}};
   localparam offload_instr_t E2 = '{instr_mask: 32'h7F, instr_data: 32'h07,
      prd_rsp: '{p_accept: 1'b1, p_writeback: 2'b00, p_is_mem_op: 1'b1, p_use_rs: 3'b001}};
   localparam offload_instr_t E3 = '{instr_mask: 32'h7F, instr_data: 32'h27,
      prd_rsp: '{p_accept: 1'b1, p_writeback: 2'b00, p_is_mem_op: 1'b1, p_use_rs: 3'b011}};
   localparam offload_instr_t [3:0] TBL = {E3, E2, E1, E0};

   logic             clk = 1'b0;
   logic             rst, flush;
   logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready, hit, multi_hit;
   logic [1:0][31:0] prd_req;
   logic [1:0][6:0]  prd_rsp;
   acc_prd_rsp_t     rsp0, rsp1;
   int               n_chk = 0, n_fail = 0;
   int               mon_sz;
   exp_t             mon_e;
   exp_t             q0[$], q1[$];

   assign rsp0 = prd_rsp[0];
   assign rsp1 = prd_rsp[1];

   always #5 clk = ~clk;

   fpu_ss_predecoder_pipe #(.NumPorts(2), .NumInstr(4), .OffloadInstr(TBL)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .prd_req_i(prd_req),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .prd_rsp_o(prd_rsp),
      .hit_o(hit), .multi_hit_o(multi_hit)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference: collect every matching entry, first one supplies the response.
   function automatic exp_t model(input logic [31:0] w);
      exp_t e;
      int   n = 0;
      e.rsp = 7'd0;
      for (int i = 0; i < 4; i++) begin
         if ((TBL[i].instr_mask & w) == TBL[i].instr_data) begin
            if (n == 0) e.rsp = TBL[i].prd_rsp;
            n++;
         end
      end
      e.hit   = (n > 0);
      e.multi = (n > 1);
      return e;
   endfunction

   function automatic logic [31:0] gen();
      logic [31:0] w = $urandom;
      case ($urandom_range(0, 4))
         0: w[6:0] = 7'h53;
         1: begin w[6:0] = 7'h53; w[14:12] = 3'b001; end
         2: w[6:0] = 7'h07;
         3: w[6:0] = 7'h27;
         default: ;
      endcase
      return w;
   endfunction

   // Issue side: record accepted requests just before the edge that captures them.
   task automatic tick();
      @(negedge clk);
      #4;
      for (int p = 0; p < 2; p++) begin
         if (req_valid[p] && req_ready[p]) begin
            if (p == 0) q0.push_back(model(prd_req[0]));
            else        q1.push_back(model(prd_req[1]));
         end
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         for (int p = 0; p < 2; p++) begin
            mon_sz = (p == 0) ? q0.size() : q1.size();
            chk($sformatf("p%0d_rsp_valid", p), 32'(rsp_valid[p]), 32'(mon_sz > 0));
            chk($sformatf("p%0d_req_ready", p), 32'(req_ready[p]), 32'(!flush && (mon_sz == 0 || rsp_ready[p])));
            if (rsp_valid[p] && mon_sz > 0) begin
               if (p == 0) mon_e = q0[0];
               else        mon_e = q1[0];
               chk($sformatf("p%0d_payload", p), 32'({prd_rsp[p], hit[p], multi_hit[p]}),
                   32'({mon_e.rsp, mon_e.hit, mon_e.multi}));
               if (rsp_ready[p]) begin
                  if (p == 0) void'(q0.pop_front());
                  else        void'(q1.pop_front());
               end
            end
            if (flush) begin
               if (p == 0) q0.delete();
               else        q1.delete();
            end
         end
      end
   end

   initial begin
      rst = 1'b1; flush = 1'b0; req_valid = '0; rsp_ready = 2'b11; prd_req = '0;
      @(posedge clk);
      #1;
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_req_ready", 32'(req_ready), 32'd3);
      chk("reset_payload", 32'({prd_rsp, hit, multi_hit}), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      // single hit on port0, aliased hit on port1
      prd_req[0] = 32'h0000_0053; prd_req[1] = 32'h0000_1053; req_valid = 2'b11;
      tick();
      chk("t1_valid", 32'(rsp_valid[0]), 32'd1);
      chk("t1_accept", 32'(rsp0.p_accept), 32'd1);
      chk("t1_use_rs", 32'(rsp0.p_use_rs), 32'b011);
      chk("t1_hit", 32'(hit[0]), 32'd1);
      chk("t1_multi", 32'(multi_hit[0]), 32'd0);
      chk("t2_wb", 32'(rsp1.p_writeback), 32'd1);
      chk("t2_multi", 32'(multi_hit[1]), 32'd1);
      prd_req[0] = 32'hFFFF_FFFF; req_valid = 2'b01;
      tick();
      chk("t6_nomatch_accept", 32'(rsp0.p_accept), 32'd0);
      chk("t6_nomatch_hit", 32'(hit[0]), 32'd0);
      req_valid = '0;
      tick();
      // port0 stalled while port1 streams
      rsp_ready = 2'b10; prd_req[0] = 32'h0000_0053; req_valid = 2'b01;
      tick();
      prd_req[0] = 32'h0000_0027;
      for (int k = 0; k < 5; k++) begin
         prd_req[1] = gen(); req_valid = 2'b11;
         tick();
         chk("t3_req_ready0", 32'(req_ready[0]), 32'd0);
         chk("t3_stable0", 32'(prd_rsp[0]), 32'(E0.prd_rsp));
         chk("t3_valid1", 32'(rsp_valid[1]), 32'd1);
      end
      rsp_ready = 2'b11;
      tick();
      req_valid = '0;
      tick();
      // back-to-back streaming
      for (int k = 0; k < 8; k++) begin
         prd_req[0] = gen(); prd_req[1] = gen(); req_valid = 2'b11;
         tick();
         chk("t4_no_bubble", 32'(rsp_valid), 32'd3);
      end
      req_valid = '0;
      tick();
      // flush while full with new requests pending
      rsp_ready = 2'b00; prd_req[0] = gen(); prd_req[1] = gen(); req_valid = 2'b11;
      tick();
      prd_req[0] = gen(); prd_req[1] = gen(); flush = 1'b1;
      #1;
      chk("t5_ready_in_flush", 32'(req_ready), 32'd0);
      tick();
      flush = 1'b0;
      chk("t5_valid_after_flush", 32'(rsp_valid), 32'd0);
      tick();
      chk("t5_accept_after_flush", 32'(rsp_valid), 32'd3);
      rsp_ready = 2'b11; req_valid = '0;
      tick();
      tick();
      // randomized traffic with occasional flush
      for (int k = 0; k < 400; k++) begin
         for (int p = 0; p < 2; p++) begin
            req_valid[p] = ($urandom_range(0, 3) != 0);
            rsp_ready[p] = ($urandom_range(0, 3) != 0);
            prd_req[p]   = gen();
         end
         flush = ($urandom_range(0, 19) == 0);
         tick();
      end
      flush = 1'b0; req_valid = '0; rsp_ready = 2'b11;
      tick();
      tick();
      // asynchronous reset while full
      rsp_ready = 2'b00; prd_req[0] = 32'h0000_0053; prd_req[1] = 32'h0000_0007; req_valid = 2'b11;
      tick();
      req_valid = '0;
      chk("t6_full_before_rst", 32'(rsp_valid), 32'd3);
      #1 rst = 1'b1;
      #1;
      chk("t6_rst_valid", 32'(rsp_valid), 32'd0);
      chk("t6_rst_payload", 32'({prd_rsp, hit, multi_hit}), 32'd0);
      q0.delete();
      q1.delete();
      @(negedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1 rsp_ready = 2'b11;
      tick();
      tick();
      chk("drain_q0", 32'(q0.size()), 32'd0);
      chk("drain_q1", 32'(q1.size()), 32'd0);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
